// File: rtl/fifo_lab_pkg.sv
// Shared defaults and elaboration-time helpers for the lab FIFO.
package fifo_lab_pkg;

    localparam int DATA_WIDTH_D = 8;
    localparam int DEPTH_D      = 64;
    localparam int PTR_D        = 6;

    // True when the entry count is exactly addressable by the pointer width.
    function automatic bit depth_matches_ptr(input int depth, input int ptr);
        return depth == (1 << ptr);
    endfunction

endpackage

// File: rtl/fifo_lab_mem.sv
// DEPTH x DATA_WIDTH register-file RAM: synchronous write, asynchronous read, no reset.
module fifo_lab_mem
    import fifo_lab_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int DEPTH      = DEPTH_D,
    parameter int PTR        = PTR_D
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fifo_lab_sync.sv
// Single-clock FIFO with registered read data and occupancy count.
// Optional sticky overflow/underflow outputs when FIFO_LAB_ERR_FLAGS_EN is defined.
module fifo_lab_sync
    import fifo_lab_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int DEPTH      = DEPTH_D,
    parameter int PTR        = PTR_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buff_in,
    output logic [DATA_WIDTH-1:0] buff_out,
    output logic [PTR:0]          fifo_counter,
    output logic                  buf_full,
`ifdef FIFO_LAB_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  buf_empty
);

    localparam logic [PTR:0] FULL_COUNT = (PTR+1)'(DEPTH);

    if (!depth_matches_ptr(DEPTH, PTR)) begin : g_bad_depth
        $error("fifo_lab_sync: DEPTH must equal 2**PTR");
    end

    logic [PTR-1:0]        wr_ptr_r;
    logic [PTR-1:0]        rd_ptr_r;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [PTR:0]          count_nxt_s;

    assign buf_full  = (fifo_counter == FULL_COUNT);
    assign buf_empty = (fifo_counter == (PTR+1)'(0));

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_acc_s = rd_en & ~buf_empty;
    assign wr_acc_s = wr_en & (~buf_full | rd_acc_s);

    // Occupancy next-state: net change of accepted write and read.
    always_comb begin
        count_nxt_s = fifo_counter;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = fifo_counter + (PTR+1)'(1);
            2'b01:   count_nxt_s = fifo_counter - (PTR+1)'(1);
            default: count_nxt_s = fifo_counter;
        endcase
    end

    fifo_lab_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR        (PTR)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (buff_in),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Pointers, counter and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= {PTR{1'b0}};
            rd_ptr_r     <= {PTR{1'b0}};
            fifo_counter <= {(PTR+1){1'b0}};
            buff_out     <= {DATA_WIDTH{1'b0}};
        end else begin
            fifo_counter <= count_nxt_s;
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR'(1);
                buff_out <= rd_data_s;
            end
        end
    end

`ifdef FIFO_LAB_ERR_FLAGS_EN
    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc_s) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc_s) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_lab_sync.sv
// Directed self-checking bench for fifo_lab_sync (vector table plus corner-case sequences).
module tb_fifo_lab_sync;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buff_in;
    logic [7:0] buff_out;
    logic [6:0] fifo_counter;
    logic       buf_full;
    logic       buf_empty;
`ifdef FIFO_LAB_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int errors = 0;
    int checks = 0;

    fifo_lab_sync dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buff_in      (buff_in),
        .buff_out     (buff_out),
        .fifo_counter (fifo_counter),
        .buf_full     (buf_full),
`ifdef FIFO_LAB_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .buf_empty    (buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic [6:0] exp_cnt;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic wr, input logic rd, input logic [7:0] din);
        wr_en   = wr;
        rd_en   = rd;
        buff_in = din;
        @(posedge clk);
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    logic [7:0] model_q [$];
    logic [7:0] exp_word;
    logic       pend_rd;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'hAB, 8'h00, 7'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'hAF, 8'h00, 7'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'hAB, 7'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'hAF, 7'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hAF, 7'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 8'hAC, 8'hAF, 7'd1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'hAC, 7'd0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'hAC, 7'd0, 1'b0, 1'b1};

        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buff_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(buff_out), 32'h00);
        check("reset_cnt", 32'(fifo_counter), 32'd0);
        check("reset_empty", 32'(buf_empty), 32'd1);
        check("reset_full", 32'(buf_full), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d_out", i), 32'(buff_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_cnt", i), 32'(fifo_counter), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_full", i), 32'(buf_full), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_empty", i), 32'(buf_empty), 32'(vecs[i].exp_empty));
        end
`ifdef FIFO_LAB_ERR_FLAGS_EN
        check("underflow_set", 32'(underflow), 32'd1);
        check("overflow_clear", 32'(overflow), 32'd0);
`endif

        // Fill, drop on overflow, drain in order.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'(i));
        check("fill_cnt", 32'(fifo_counter), 32'd64);
        check("fill_full", 32'(buf_full), 32'd1);
        check("fill_empty", 32'(buf_empty), 32'd0);
        step(1'b1, 1'b0, 8'hFF);
        check("ovf_cnt", 32'(fifo_counter), 32'd64);
        check("ovf_out", 32'(buff_out), 32'hAC);
`ifdef FIFO_LAB_ERR_FLAGS_EN
        check("overflow_set", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d", i), 32'(buff_out), 32'(i));
        end
        check("drain_empty", 32'(buf_empty), 32'd1);
        check("drain_cnt", 32'(fifo_counter), 32'd0);

        // Simultaneous read+write while full.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'(i));
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 8'(8'h80 + k));
            check($sformatf("full_rw%0d_cnt", k), 32'(fifo_counter), 32'd64);
            check($sformatf("full_rw%0d_out", k), 32'(buff_out), 32'(k));
        end
        for (int i = 0; i < 64; i++) begin
            exp_word = (i < 56) ? 8'(i + 8) : 8'(8'h80 + i - 56);
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("full_rw_drain%0d", i), 32'(buff_out), 32'(exp_word));
        end
        check("full_rw_empty", 32'(buf_empty), 32'd1);

        // 100 writes with interleaved reads; pointers wrap past 64.
        pend_rd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            logic rd;
            rd = (i % 3) != 0;
            if (rd && model_q.size() > 0) begin
                exp_word = model_q.pop_front();
                pend_rd = 1'b1;
            end else begin
                pend_rd = 1'b0;
            end
            model_q.push_back(8'(8'h20 + i));
            step(1'b1, rd, 8'(8'h20 + i));
            if (pend_rd) check($sformatf("wrap%0d", i), 32'(buff_out), 32'(exp_word));
            check($sformatf("wrap%0d_cnt", i), 32'(fifo_counter), 32'(model_q.size()));
        end
        for (int j = 0; j < 64 && model_q.size() > 0; j++) begin
            exp_word = model_q.pop_front();
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("wrap_drain%0d", j), 32'(buff_out), 32'(exp_word));
        end
        check("wrap_empty", 32'(buf_empty), 32'd1);

        // Asynchronous reset between edges with five entries queued.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
        step(1'b0, 1'b1, 8'h00);
        check("pre_rst_cnt", 32'(fifo_counter), 32'd5);
        check("pre_rst_out", 32'(buff_out), 32'h11);
        #2 rst = 1'b0;
        #1;
        check("async_rst_cnt", 32'(fifo_counter), 32'd0);
        check("async_rst_empty", 32'(buf_empty), 32'd1);
        check("async_rst_out", 32'(buff_out), 32'h00);
`ifdef FIFO_LAB_ERR_FLAGS_EN
        check("async_rst_ovf", 32'(overflow), 32'd0);
        check("async_rst_udf", 32'(underflow), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_out", 32'(buff_out), 32'h5A);
        check("post_rst_cnt", 32'(fifo_counter), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_lab_sync.md
Name: fifo_lab_sync

Overview:
- Single-clock synchronous FIFO with a registered read port and an occupancy counter.
- Buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain.
- Used as the general-purpose lab buffering block. Provides full/empty status and an occupancy count.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 64, number of entries; must equal 2**PTR.
- PTR, 6, address (pointer) width in bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- buff_in  input  DATA_WIDTH  write data.
- buff_out  output  DATA_WIDTH  registered read data.
- fifo_counter  output  PTR+1  current occupancy, range 0..DEPTH.
- buf_full  output  1  high when fifo_counter == DEPTH.
- buf_empty  output  1  high when fifo_counter == 0.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, fifo_counter = 0, buff_out = 0.
  - buf_empty = 1, buf_full = 0.
  - Memory contents are not reset.
- Accept rules:
  - wr_acc = wr_en & (!buf_full | rd_acc).
  - rd_acc = rd_en & !buf_empty.
- Write: on wr_acc, mem[wr_ptr] <= buff_in and wr_ptr increments.
- Read: on rd_acc, buff_out <= mem[rd_ptr] and rd_ptr increments.
  - Data is visible on buff_out one clock after the accepting edge.
  - buff_out holds its last value when no read is accepted.
- Pointers are PTR bits wide and wrap naturally from DEPTH-1 to 0.
- fifo_counter updates at the same edge:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on both or neither.
- Simultaneous events:
  - Both requested, FIFO neither full nor empty: both accepted, count unchanged.
  - Both requested, FIFO full: read accepted, so the write is also accepted; count stays DEPTH.
  - Both requested, FIFO empty: write accepted, read ignored; buff_out unchanged; count becomes 1.
  - There is no write-to-read bypass.
- Overflow (wr_en while full, no read): write dropped, no state change.
- Underflow (rd_en while empty): read ignored, buff_out holds.
- buf_full and buf_empty are combinational decodes of fifo_counter.
- Reset asserted mid-operation immediately returns all state to reset values; queued data is lost.

Optional Feature:
- Macro: FIFO_LAB_ERR_FLAGS_EN.
- Defined: adds outputs overflow (1) and underflow (1).
  - overflow is sticky; set on a dropped write.
  - underflow is sticky; set on an ignored read.
  - Both are cleared only by reset.
- Undefined: these ports and their logic are absent; core behaviour is identical.

Decomposition:
- Package fifo_lab_pkg holds:
  - Default constants DATA_WIDTH_D=8, DEPTH_D=64, PTR_D=6.
  - A compile-time check that DEPTH == 2**PTR.
- Sub-module fifo_lab_mem:
  - Simple dual-port register-file RAM, DEPTH x DATA_WIDTH.
  - Synchronous write port; asynchronous read address.
  - No reset.
- Top level holds pointers, counter, flags and the buff_out register.

Test Plan:
- Reset, then write 0xAB and 0xAF on consecutive cycles, then read twice -> buff_out = 0xAB one cycle after the first read edge, then 0xAF; fifo_counter goes 0,1,2,1,0; buf_empty = 1 at end.
- Write 64 words 0x00..0x3F -> buf_full = 1, fifo_counter = 64; a 65th write of 0xFF is dropped (overflow = 1 if enabled); 64 reads return 0x00..0x3F in order.
- Fill to 64, then assert wr_en and rd_en together for 8 cycles writing 0x80..0x87 -> count stays 64; later reads yield 0x08..0x3F followed by 0x80..0x87.
- Read on empty with buff_out previously 0xAF -> buff_out stays 0xAF, count stays 0 (underflow = 1 if enabled); simultaneous read+write on empty -> count 1, next read returns the written word.
- Write 100 words with interleaved reads to force pointer wrap -> output sequence matches input order exactly.
- Assert rst low asynchronously between clock edges with count 5 -> count 0, buf_empty = 1, buff_out = 0x00 immediately, without waiting for a clock edge.
